// File: rtl/run_ctrl.sv
// run_ctrl: sequences the MIPS core reset, then counts RUN cycles and retired
// instructions until an error, a self-loop halt or a watchdog timeout ends the run.
// Ports: clk, reset (sync, active-low) | start | retire_valid/retire_pc, error_in
//        -> core_reset, running, done, halted/timed_out/errored, cycle_cnt, retire_cnt.
module run_ctrl #(
  parameter int RST_CYCLES  = 4,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 100000,
  parameter int HALT_REPEAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [PC_W-1:0]  retire_pc,
  input  logic             error_in,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timed_out,
  output logic             errored,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int RW = (RST_CYCLES  < 1) ? 1 : $clog2(RST_CYCLES + 1);
  localparam int LW = (HALT_REPEAT < 1) ? 1 : $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  state_t           state_q;
  logic [RW-1:0]    rst_cnt_q;
  logic [LW-1:0]    loop_cnt_q;
  logic [PC_W-1:0]  last_pc_q;
  logic             last_vld_q;
  logic             core_reset_q, running_q, done_q;
  logic             halted_q, timed_out_q, errored_q;
  logic [CNT_W-1:0] cycle_cnt_q, retire_cnt_q;

  logic [CNT_W-1:0] cycle_cnt_d, retire_cnt_d;
  logic [LW-1:0]    loop_cnt_d;
  logic             same_pc, halt_evt, timeout_evt, rst_last;

  always_comb begin
    cycle_cnt_d  = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    retire_cnt_d = (retire_valid && !(&retire_cnt_q)) ? retire_cnt_q + CNT_W'(1)
                                                        : retire_cnt_q;
    same_pc      = retire_valid && last_vld_q && (retire_pc == last_pc_q);
    loop_cnt_d   = loop_cnt_q + LW'(1);
    // Halt fires when the repeat count after this retire reaches HALT_REPEAT.
    halt_evt     = same_pc && (loop_cnt_d == LW'(HALT_REPEAT));
    // Compare against TIMEOUT-1 so the exit cycle itself lands cycle_cnt on TIMEOUT.
    timeout_evt  = (cycle_cnt_q == CNT_W'(TIMEOUT - 1));
    rst_last     = (rst_cnt_q == RW'(RST_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      loop_cnt_q   <= '0;
      last_pc_q    <= '0;
      last_vld_q   <= 1'b0;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      halted_q     <= 1'b0;
      timed_out_q  <= 1'b0;
      errored_q    <= 1'b0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      case (state_q)
        // IDLE and DONE share the start path; core_reset differs but is held.
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_RST;
            rst_cnt_q    <= '0;
            loop_cnt_q   <= '0;
            last_vld_q   <= 1'b0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
            errored_q    <= 1'b0;
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
          end
        end
        S_RST: begin
          if (rst_last) begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
            running_q    <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + RW'(1);
          end
        end
        S_RUN: begin
          // Counters advance on the exit cycle too.
          cycle_cnt_q  <= cycle_cnt_d;
          retire_cnt_q <= retire_cnt_d;
          if (retire_valid) begin
            if (same_pc) begin
              loop_cnt_q <= loop_cnt_d;
            end else begin
              loop_cnt_q <= '0;
              last_pc_q  <= retire_pc;
              last_vld_q <= 1'b1;
            end
          end
          if (error_in || halt_evt || timeout_evt) begin
            state_q     <= S_DONE;
            running_q   <= 1'b0;
            done_q      <= 1'b1;
            errored_q   <= error_in;
            halted_q    <= !error_in && halt_evt;
            timed_out_q <= !error_in && !halt_evt;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_reset = core_reset_q;
  assign running    = running_q;
  assign done       = done_q;
  assign halted     = halted_q;
  assign timed_out  = timed_out_q;
  assign errored    = errored_q;
  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_run_ctrl;

  localparam int RST_CYCLES  = 4;
  localparam int TIMEOUT     = 20;
  localparam int HALT_REPEAT = 4;

  localparam int M_IDLE = 0;
  localparam int M_RST  = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        retire_valid;
  logic [31:0] retire_pc;
  logic        error_in;
  logic        core_reset, running, done, halted, timed_out, errored;
  logic [31:0] cycle_cnt, retire_cnt;

  run_ctrl #(
    .RST_CYCLES (RST_CYCLES),
    .PC_W       (32),
    .CNT_W      (32),
    .TIMEOUT    (TIMEOUT),
    .HALT_REPEAT(HALT_REPEAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .retire_valid(retire_valid),
    .retire_pc   (retire_pc),
    .error_in    (error_in),
    .core_reset  (core_reset),
    .running     (running),
    .done        (done),
    .halted      (halted),
    .timed_out   (timed_out),
    .errored     (errored),
    .cycle_cnt   (cycle_cnt),
    .retire_cnt  (retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: phase, remaining reset cycles, plain counters and the
  // length of the current streak of identical retired PCs.
  int          m_mode = M_IDLE;
  int          m_rst_left = 0;
  longint      m_cyc = 0, m_ret = 0;
  int          m_streak = 0;
  logic [31:0] m_pc = '0;
  bit          m_have = 1'b0;
  bit          m_halt = 1'b0, m_to = 1'b0, m_err = 1'b0;

  task automatic model_begin_run();
    m_mode = M_RST; m_rst_left = RST_CYCLES;
    m_cyc = 0; m_ret = 0; m_halt = 0; m_to = 0; m_err = 0;
    m_streak = 0; m_have = 0;
  endtask

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic model_step();
    bit halt_now;
    if (!reset) begin
      m_mode = M_IDLE; m_cyc = 0; m_ret = 0; m_halt = 0; m_to = 0; m_err = 0;
      m_streak = 0; m_have = 0;
      return;
    end
    case (m_mode)
      M_IDLE, M_DONE: if (start) model_begin_run();
      M_RST: begin
        m_rst_left--;
        if (m_rst_left == 0) m_mode = M_RUN;
      end
      default: begin
        m_cyc++;
        halt_now = 0;
        if (retire_valid) begin
          m_ret++;
          if (m_have && retire_pc == m_pc) m_streak++;
          else begin m_streak = 1; m_pc = retire_pc; m_have = 1; end
          // HALT_REPEAT repeats means HALT_REPEAT+1 identical retires in a row.
          halt_now = (m_streak == HALT_REPEAT + 1);
        end
        if (error_in)             begin m_mode = M_DONE; m_err  = 1; end
        else if (halt_now)        begin m_mode = M_DONE; m_halt = 1; end
        else if (m_cyc == TIMEOUT) begin m_mode = M_DONE; m_to   = 1; end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [69:0] act, exp;
      act = {core_reset, running, done, halted, timed_out, errored, cycle_cnt, retire_cnt};
      exp = {(m_mode == M_IDLE || m_mode == M_RST), (m_mode == M_RUN), (m_mode == M_DONE),
             m_halt, m_to, m_err, 32'(m_cyc), 32'(m_ret)};
      n_assert++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL cycle_cmp at %0t: dut cr=%b run=%b dn=%b h=%b t=%b e=%b cyc=%0d ret=%0d model cr=%b run=%b dn=%b h=%b t=%b e=%b cyc=%0d ret=%0d",
                 $time, act[69], act[68], act[67], act[66], act[65], act[64], act[63:32], act[31:0],
                 exp[69], exp[68], exp[67], exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
      end
    end
  end

  task automatic wait_run();
    int k;
    k = 0;
    while (!running && k < 50) begin tick(); k++; end
    check("wait_run", running, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic retire(logic [31:0] pc, bit err);
    retire_valid = 1'b1; retire_pc = pc; error_in = err;
    tick();
    retire_valid = 1'b0; error_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, k;
    logic [31:0] cur_pc;

    reset = 1'b0; start = 1'b0; retire_valid = 1'b0; retire_pc = '0; error_in = 1'b0;

    // Reset and start
    tick();
    chk_en = 1'b1;
    tick(); tick();
    check("rst_core_reset", core_reset, 1);
    check("rst_done", done, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    reset = 1'b1;
    tick();
    do_start();
    cnt = 0; k = 0;
    while (core_reset && k < 20) begin cnt++; tick(); k++; end
    check("rst_hold_cycles", cnt, RST_CYCLES);
    check("run_after_rst", running, 1);
    check("run_cycle_cnt0", cycle_cnt, 0);

    // Halt: 0x3000, 0x3004, then 0x3008 five times
    retire(32'h3000, 0);
    retire(32'h3004, 0);
    for (int i = 0; i < 5; i++) begin
      check("halt_not_early", done, 0);
      retire(32'h3008, 0);
    end
    check("halt_done", done, 1);
    check("halt_flag", halted, 1);
    check("halt_retire_cnt", retire_cnt, 7);
    check("halt_cycle_cnt", cycle_cnt, 7);
    check("model_halt_ret", m_ret, 7);

    // Restart from DONE, second halt run
    do_start();
    check("restart_done", done, 0);
    check("restart_flags", {halted, timed_out, errored}, 0);
    check("restart_cnt", retire_cnt, 0);
    for (int i = 0; i < RST_CYCLES - 1; i++) tick();
    check("restart_core_reset", core_reset, 1);
    tick();
    check("restart_running", running, 1);
    for (int i = 0; i < 5; i++) retire(32'h40, 0);
    check("halt2_flag", halted, 1);
    check("halt2_retire_cnt", retire_cnt, 5);

    // Priority: error on the halt-completing retire
    do_start();
    wait_run();
    for (int i = 0; i < 4; i++) retire(32'h80, 0);
    retire(32'h80, 1);
    check("prio_errored", errored, 1);
    check("prio_halted", halted, 0);
    check("prio_retire_cnt", retire_cnt, 5);

    // Timeout with no retires
    do_start();
    wait_run();
    cnt = 0;
    while (!done && cnt < 100) begin tick(); cnt++; end
    check("to_run_cycles", cnt, TIMEOUT);
    check("to_cycle_cnt", cycle_cnt, TIMEOUT);
    check("to_flags", {halted, timed_out, errored}, 3'b010);

    // Abort mid-RUN at cycle_cnt 7
    do_start();
    wait_run();
    repeat (7) tick();
    check("abort_cyc7", cycle_cnt, 7);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_core_reset", core_reset, 1);
    check("abort_outs", {running, done, cycle_cnt, retire_cnt}, 0);

    // Randomized phase
    cur_pc = 32'h200;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) != 0);
      start = ($urandom_range(0, 2) == 0);
      retire_valid = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) cur_pc = 32'h200 + 32'($urandom_range(0, 2)) * 4;
      retire_pc = cur_pc;
      error_in = ($urandom_range(0, 39) == 0);
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
